// File: rtl/rotl_pkg.sv
// Shared types and defaults for the sequential left rotator.
package rotl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } rotl_state_t;

   localparam int ROTL_WIDTH_DEFAULT = 8;

endpackage : rotl_pkg

// File: rtl/rotl_seq_shifter.sv
// Multi-cycle left rotator: rotates a WIDTH-bit word left by amt, one bit
// per clock, with valid/ready handshakes on the input and output sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready high, y holds last result
// SHIFT | rotating data left one bit per clock until count reaches 1
// DONE  | result presented on y with out_valid high until out_ready
module rotl_seq_shifter
   import rotl_pkg::*;
#(
   parameter  int WIDTH = ROTL_WIDTH_DEFAULT,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y
);

   rotl_state_t      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] count_q, count_d;

   // Next-state, next-data and next-count decode for the rotate sequencer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = a;
               count_d = amt;
               state_d = (amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // SHIFT is only entered with count >= 1, so the decrement never wraps.
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            count_d = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // No new operation is accepted on the output handshake edge.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, data and count registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = data_q;

endmodule : rotl_seq_shifter

// File: doc/rotl_seq_shifter.md
Name: rotl_seq_shifter

Overview:
- Multi-cycle left rotator, the opposite direction of the team's combinational right-rotate barrel shifter.
- Rotates a WIDTH-bit word left by amt positions, one bit per clock, using a valid/ready handshake on both input and output.
- Used where area matters more than latency, and in benches as the inverse model: a right rotate by k of this block's result by k restores the original word.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- AMT_W, $clog2(WIDTH), width of the rotate amount; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a and amt are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand.
- amt  input  AMT_W  left-rotate amount, 0..WIDTH-1.
- out_valid  output  1  y holds the final result.
- out_ready  input  1  consumer accepts y.
- y  output  WIDTH  rotated result.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE.
  - data register = 0, so y = 0.
  - count = 0.
  - out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state only.
- y is always driven from the data register.
- IDLE:
  - When in_valid && in_ready at a rising edge: load the data register with a and count with amt.
  - Next state is DONE if amt == 0, otherwise SHIFT.
  - If in_valid is low, stay in IDLE. The data register and y keep their last value.
- SHIFT, each edge:
  - data <= {data[WIDTH-2:0], data[WIDTH-1]}.
  - count <= count - 1.
  - When count == 1 at that edge, next state is DONE.
  - in_valid is ignored.
- DONE:
  - Hold y stable while out_ready is low, for any number of cycles.
  - On out_ready high at an edge, go to IDLE.
  - in_valid is ignored in DONE. The block does not accept a new operation in the same cycle as the output handshake.
- Latency:
  - out_valid rises amt+1 cycles after the accepting edge's cycle: amt=0 gives 1, amt=WIDTH-1 gives WIDTH.
  - Minimum issue interval is amt+2 cycles, with out_ready tied high.
- Arithmetic:
  - Rotation is modulo WIDTH; no bits are lost.
  - count never underflows, because SHIFT is entered only with count >= 1.
- Reset mid-operation (SHIFT or DONE):
  - Abort the operation and go to IDLE with data = 0.
  - out_valid = 0 the cycle after reset; no partial result is ever presented.
- Inputs a and amt are sampled only at the accepting edge. Later changes have no effect.

Decomposition:
- Package rotl_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} rotl_state_t;
  - localparam int ROTL_WIDTH_DEFAULT = 8.
- No sub-module. The single-bit rotate is an inline concatenation, and the FSM, counter and data register live in one always_ff block plus one next-state always_comb block.

Test Plan:
- Basic rotate: a=8'hB4, amt=3, in_valid for 1 cycle, out_ready=1 -> out_valid high for 1 cycle, 4 cycles after acceptance, with y=8'hA5; in_ready back to 1 the following cycle.
- Boundary amounts:
  - a=8'h5A, amt=0 -> y=8'h5A, out_valid 1 cycle after acceptance.
  - a=8'h01, amt=7 -> y=8'h80 after 8 cycles.
- Backpressure: a=8'hC3, amt=2, out_ready held low for 5 cycles after out_valid rises -> y=8'h0F stable and out_valid high throughout; in_ready=0 throughout; an in_valid pulse with a=8'hFF during the stall is ignored; out_ready high -> IDLE.
- Reset mid-shift: a=8'h81, amt=6, reset asserted on the 3rd SHIFT cycle -> next cycle out_valid=0, y=8'h00, in_ready=1; a new op a=8'h81, amt=1 -> y=8'h03.
- Back-to-back and inverse check:
  - Exhaustive sweep of all 256 values of a × all 8 amt values with out_ready=1 and in_valid held high.
  - Each result checked against a reference right-rotate: rotr(y, amt) == a.
  - in_ready returns to 1 exactly one cycle after each output handshake.
